rst_encoder: RTL

- Control-side issuer for the register-reset bus: converts per-register reset requests into the one-hot select plus enable-pulse protocol consumed by the reset decoder.
- Latches ROW/COL/CURR/SUM requests and arbitrates among them by fixed priority.
- Sequences each request as setup, then enable pulse, then hold, so the select is stable around every enable pulse.
- Sits in the processor control unit, driving RST_sel/RST_en toward the row/col/curr/sum counters.

---
 rtl/rst_encoder.sv | 98 +++++++++
 1 files changed

// File: rtl/rst_encoder.sv
// Register-reset bus issuer: latches per-register reset requests and plays each
// one out as select setup, enable pulse, select hold, then a one-cycle done.
module rst_encoder #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] RST_sel,
    output logic       RST_en,
    output logic       busy,
    output logic [3:0] done
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    state_t     state;
    logic [3:0] pending;
    logic [3:0] cnt;
    logic [1:0] grant;
    logic [1:0] prio;
    logic [3:0] clr;
    logic       hold_end;

    // Fixed priority: lowest set bit (ROW) wins.
    always_comb begin
        prio = 2'd3;
        for (int i = 3; i >= 0; i--)
            if (pending[i]) prio = 2'(i);
    end

    assign hold_end = (state == HOLD) && (cnt == 4'd0);
    // A request landing on the clearing edge still survives (set wins).
    assign clr = hold_end ? (4'b0001 << grant) : 4'b0000;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            cnt     <= '0;
            grant   <= '0;
            RST_sel <= '0;
            RST_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= '0;
        end else begin
            pending <= (pending & ~clr) | req;
            done    <= '0;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state   <= SETUP;
                        grant   <= prio;
                        cnt     <= SETUP_LD;
                        RST_sel <= 4'b0001 << prio;
                        busy    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        state  <= PULSE;
                        cnt    <= PULSE_LD;
                        RST_en <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                PULSE: begin
                    if (cnt == 4'd0) begin
                        state  <= HOLD;
                        cnt    <= HOLD_LD;
                        RST_en <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        state   <= IDLE;
                        RST_sel <= '0;
                        busy    <= 1'b0;
                        done    <= 4'b0001 << grant;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
